// File: rtl/formula_sweep_pkg.sv
// Shared types and constants for the Boolean formula sweep sequencer.
package formula_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_SAT   = 1'b0;
   localparam logic MODE_EQUIV = 1'b1;

   // One extra bit so a full sweep where every assignment hits still fits.
   function automatic int cnt_width(input int num_vars);
      return num_vars + 1;
   endfunction

endpackage

// File: rtl/formula_sweep_ctrl.sv
// Sweeps every input assignment of an external combinational formula and
// counts hits (satisfying assignments or candidate/spec mismatches).
module formula_sweep_ctrl
   import formula_sweep_pkg::*;
#(
   parameter int NUM_VARS = 4,
   parameter int CNT_W    = cnt_width(NUM_VARS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   input  logic                mode,
   input  logic                stop_on_hit,
   output logic [NUM_VARS-1:0] assign_out,
   input  logic                eval_a,
   input  logic                eval_b,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic [CNT_W-1:0]    hit_cnt,
   output logic                hit_found,
   output logic [NUM_VARS-1:0] first_hit
);

   state_t              state, state_n;
   logic                mode_q, stop_q;
   logic                hit, last;
   logic [NUM_VARS-1:0] assign_q, first_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                found_q, aborted_q;

   // Formula outputs settle combinationally from the registered assignment.
   assign hit  = (mode_q == MODE_EQUIV) ? (eval_a ^ eval_b) : eval_a;
   assign last = &assign_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (abort || (hit && stop_q) || last) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= 1'b0;
         stop_q    <= 1'b0;
         assign_q  <= '0;
         first_q   <= '0;
         cnt_q     <= '0;
         found_q   <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q    <= mode;
                  stop_q    <= stop_on_hit;
                  assign_q  <= '0;
                  first_q   <= '0;
                  cnt_q     <= '0;
                  found_q   <= 1'b0;
                  aborted_q <= 1'b0;
               end
            end
            RUN: begin
               // Abort discards this cycle's evaluation entirely.
               if (abort) begin
                  aborted_q <= 1'b1;
               end else begin
                  if (hit) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                     if (!found_q) begin
                        first_q <= assign_q;
                        found_q <= 1'b1;
                     end
                  end
                  if (!(hit && stop_q) && !last) begin
                     assign_q <= assign_q + NUM_VARS'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign assign_out = assign_q;
   assign busy       = (state == RUN);
   assign done       = (state == DONE);
   assign aborted    = aborted_q;
   assign hit_cnt    = cnt_q;
   assign hit_found  = found_q;
   assign first_hit  = first_q;

endmodule

// File: tb/tb_formula_sweep_ctrl.sv
// Bench for formula_sweep_ctrl: truth-table formulas, directed and random sweeps.
module tb_formula_sweep_ctrl;

   localparam int NV = 4;
   localparam int CW = NV + 1;

   logic          clk = 1'b0;
   logic          rst, start, abort, mode, stop_on_hit;
   logic [NV-1:0] assign_out, first_hit;
   logic          eval_a, eval_b, busy, done, aborted, hit_found;
   logic [CW-1:0] hit_cnt;
   logic [15:0]   ta_tab, tb_tab;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign eval_a = ta_tab[assign_out];
   assign eval_b = tb_tab[assign_out];

   formula_sweep_ctrl #(.NUM_VARS(NV)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .stop_on_hit(stop_on_hit), .assign_out(assign_out), .eval_a(eval_a),
      .eval_b(eval_b), .busy(busy), .done(done), .aborted(aborted),
      .hit_cnt(hit_cnt), .hit_found(hit_found), .first_hit(first_hit)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: walk assignments in order, applying the hit / stop / abort rules.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic m,
                        input logic s, input int abort_at,
                        output int cnt, output int first, output int found,
                        output int last, output int ab, output int dc);
      cnt = 0; first = 0; found = 0; last = 0; ab = 0; dc = 0;
      for (int k = 0; k < 16; k++) begin
         bit h;
         if (k == abort_at) begin
            ab = 1; last = k; dc = k + 2;
            break;
         end
         h = m ? (a[k] ^ b[k]) : a[k];
         if (h) begin
            cnt++;
            if (found == 0) begin
               found = 1; first = k;
            end
         end
         if ((h && s) || k == 15) begin
            last = k; dc = k + 2;
            break;
         end
      end
   endtask

   task automatic do_sweep(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic m, input logic s, input int abort_at, input bit disturb);
      int e_cnt, e_first, e_found, e_last, e_ab, e_dc;
      int dc, busy_cnt;
      dc = -1; busy_cnt = 0;
      model(a, b, m, s, abort_at, e_cnt, e_first, e_found, e_last, e_ab, e_dc);
      @(negedge clk);
      ta_tab = a; tb_tab = b; mode = m; stop_on_hit = s; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (done) begin
            dc = c;
            break;
         end
         if (busy) busy_cnt++;
         abort = (int'(assign_out) == abort_at);
         if (disturb) begin
            start = 1'b1; mode = ~m; stop_on_hit = ~s;
         end
         @(negedge clk);
      end
      abort = 1'b0; start = 1'b0; mode = m; stop_on_hit = s;
      chk({tag, "_done_cycle"}, dc, e_dc);
      chk({tag, "_busy_cycles"}, busy_cnt, e_dc - 1);
      chk({tag, "_busy_at_done"}, busy, 0);
      chk({tag, "_hit_cnt"}, hit_cnt, e_cnt);
      chk({tag, "_hit_found"}, hit_found, e_found);
      chk({tag, "_first_hit"}, first_hit, e_first);
      chk({tag, "_aborted"}, aborted, e_ab);
      chk({tag, "_assign_out"}, assign_out, e_last);
      @(negedge clk);
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_hold_cnt"}, hit_cnt, e_cnt);
   endtask

   initial begin
      int pulses;
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; stop_on_hit = 1'b0;
      ta_tab = '0; tb_tab = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_assign", assign_out, 0);
      chk("rst_cnt", hit_cnt, 0);
      rst = 1'b0;

      do_sweep("sat_and01", 16'h8888, 16'h0000, 1'b0, 1'b0, -1, 1'b0);
      do_sweep("eqv_same", 16'hF0F0, 16'hF0F0, 1'b1, 1'b0, -1, 1'b0);
      do_sweep("eqv_inv", 16'hF0F0, 16'h0F0F, 1'b1, 1'b0, -1, 1'b0);
      do_sweep("stop_at9", 16'h0200, 16'h0000, 1'b0, 1'b1, -1, 1'b0);
      do_sweep("abort5", 16'h8888, 16'h0000, 1'b0, 1'b0, 5, 1'b0);
      do_sweep("abort15", 16'hFFFF, 16'h0000, 1'b0, 1'b0, 15, 1'b0);
      do_sweep("all_hit", 16'hFFFF, 16'h0000, 1'b0, 1'b0, -1, 1'b0);
      do_sweep("disturb", 16'h8888, 16'h0000, 1'b0, 1'b0, -1, 1'b1);

      // Mid-sweep reset
      @(negedge clk);
      ta_tab = 16'h8888; mode = 1'b0; stop_on_hit = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && assign_out != 4'd7; i++) @(negedge clk);
      chk("rst_reach7", assign_out, 7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_assign", assign_out, 0);
      chk("midrst_cnt", hit_cnt, 0);
      chk("midrst_found", hit_found, 0);
      chk("midrst_first", first_hit, 0);
      chk("midrst_aborted", aborted, 0);
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      chk("midrst_idle", pulses, 0);
      do_sweep("after_rst", 16'h8888, 16'h0000, 1'b0, 1'b0, -1, 1'b0);

      for (int r = 0; r < 8; r++) begin
         logic [15:0] a, b;
         int ab_at;
         a = 16'($urandom) & ((r % 2) ? 16'($urandom) : 16'hFFFF);
         b = 16'($urandom);
         ab_at = $urandom_range(0, 31);
         if (ab_at > 15) ab_at = -1;
         do_sweep($sformatf("rnd%0d", r), a, b, 1'($urandom), 1'($urandom), ab_at,
                  1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
